bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_to_bin_seq_if.sv | 32 +++
 rtl/bcd_digit_mac.sv | 23 ++
 rtl/bcd_to_bin_seq.sv | 126 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
// Purpose: state encoding, default geometry and the largest legal BCD digit.
// Ports: none (package).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NDIG_DEFAULT = 3;
  localparam int BW_DEFAULT   = 10;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - producer/consumer handshake bundle for bcd_to_bin_seq
// Purpose: groups the input word handshake and the result handshake.
// Ports (signals):
//   in_valid/in_ready/bcd_in        - packed BCD word from the producer
//   out_valid/out_ready/bin_out/err - binary result to the consumer
// Modports: master = producer/consumer side, slave = converter side.
interface bcd_to_bin_seq_if
  import bcd_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT,
  parameter int BW   = BW_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] bcd_in;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     bin_out;
  logic              err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - combinational acc*10 + digit step
// Purpose: one Horner step of decimal-to-binary conversion.
// Ports:
//   acc           in  BW  running binary value
//   digit         in  4   next BCD digit (most significant first)
//   acc_next      out BW  acc*10 + digit, truncated to BW bits
//   digit_illegal out 1   digit is not a decimal digit (> 9)
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic [BW-1:0] acc,
  input  logic [3:0]    digit,
  output logic [BW-1:0] acc_next,
  output logic          digit_illegal
);

  // x*10 = x*8 + x*2, avoiding a generic multiplier
  assign acc_next      = (acc << 3) + (acc << 1) + BW'(digit);
  assign digit_illegal = (digit > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter
// Purpose: accepts one NDIG-digit packed BCD word, converts it MSD-first
//          over NDIG cycles and presents the binary result until consumed.
//          Words containing a nibble > 9 are flagged with err and bin_out=0.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of bcd_to_bin_seq_if (both handshakes)
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT,
  parameter int BW   = BW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state_q, state_d;
  logic [4*NDIG-1:0] word_q,  word_d;
  logic [BW-1:0]     acc_q,   acc_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              err_q,   err_d;

  logic              illegal_in;
  logic [3:0]        cur_digit;
  logic [BW-1:0]     mac_sum;
  logic              mac_illegal;

  bcd_digit_mac #(.BW(BW)) u_mac (
    .acc           (acc_q),
    .digit         (cur_digit),
    .acc_next      (mac_sum),
    .digit_illegal (mac_illegal)
  );

  // Screen every nibble of the offered word so a bad word skips conversion
  always_comb begin
    illegal_in = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (bus.bcd_in[4*k +: 4] > BCD_MAX_DIGIT) illegal_in = 1'b1;
    end
  end

  // cnt counts from 0, so digit NDIG-1-cnt walks from the top nibble down
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (CW'(NDIG - 1 - k) == cnt_q) cur_digit = word_q[4*k +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d = bus.bcd_in;
          acc_d  = '0;
          cnt_d  = '0;
          if (illegal_in) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        acc_d = mac_sum;
        // Cannot fire for a screened word; kept sticky as a safety net
        err_d = err_q | mac_illegal;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode state only; results are masked outside DONE
  // because acc holds partial sums during CONV.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin_out   = (state_q == DONE) ? acc_q : '0;
  assign bus.err       = (state_q == DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - randomized self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

  localparam int NDIG = 3;
  localparam int BW   = 10;
  localparam int WW   = 4 * NDIG;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_bin_seq_if #(.NDIG(NDIG), .BW(BW)) bus ();

  bcd_to_bin_seq #(.NDIG(NDIG), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: decimal value of the digits, illegal if any nibble exceeds 9
  task automatic ref_model(input logic [WW-1:0] w, output int val, output bit ill);
    int d;
    val = 0;
    ill = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      d = int'(w[4*k +: 4]);
      if (d > 9) ill = 1'b1;
      val = val * 10 + d;
    end
  endtask

  function automatic logic [WW-1:0] to_bcd(input int v);
    logic [WW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Offer one word from IDLE, check latency/masking/result, hold for 'hold'
  // cycles with out_ready low, then consume. Called and returns at a negedge.
  task automatic run_word(input logic [WW-1:0] w, input int hold);
    int  exp_val;
    bit  exp_ill;
    int  lat;
    logic [BW-1:0] seen_bin;
    ref_model(w, exp_val, exp_ill);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.bcd_in    = w;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.bcd_in   = WW'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check("busy_bin_masked", 32'(bus.bin_out), 32'd0);
      check("busy_err_masked", 32'(bus.err), 32'd0);
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), exp_ill ? 32'd0 : 32'(NDIG));
    check("bin_out", 32'(bus.bin_out), exp_ill ? 32'd0 : 32'(exp_val));
    check("err", 32'(bus.err), 32'(exp_ill));
    seen_bin = bus.bin_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_bin", 32'(bus.bin_out), 32'(seen_bin));
      check("hold_err", 32'(bus.err), 32'(exp_ill));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("consumed_valid", 32'(bus.out_valid), 32'd0);
    check("consumed_in_ready", 32'(bus.in_ready), 32'd1);
    check("consumed_bin", 32'(bus.bin_out), 32'd0);
  endtask

  initial begin
    logic [WW-1:0] w;
    int lows;
    int t;
    int got1;
    int err1;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_bin", 32'(bus.bin_out), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words: max value, illegal nibble, long consumer stall
    run_word(WW'(12'h999), 0);
    run_word(WW'(12'h0A5), 0);
    run_word(WW'(12'h507), 5);

    // Back-to-back with in_valid held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bcd_in    = WW'(12'h042);
    @(negedge clk);
    bus.bcd_in = WW'(12'h000);
    lows = 0;
    t    = 0;
    got1 = -1;
    err1 = -1;
    while (!bus.in_ready && t < 20) begin
      if (bus.out_valid) begin
        got1 = int'(bus.bin_out);
        err1 = int'(bus.err);
      end
      lows++;
      t++;
      @(negedge clk);
    end
    check("b2b_gap", 32'(lows), 32'd4);
    check("b2b_first_bin", 32'(got1), 32'd42);
    check("b2b_first_err", 32'(err1), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_second_bin", 32'(bus.bin_out), 32'd0);
    check("b2b_second_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_idle", 32'(bus.in_ready), 32'd1);

    // Reset during the second CONV cycle discards the word
    bus.in_valid = 1'b1;
    bus.bcd_in   = WW'(12'h321);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_bin", 32'(bus.bin_out), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_word(WW'(12'h100), 0);

    // Exhaustive legal sweep
    for (int v = 0; v < 1000; v++) begin
      run_word(to_bcd(v), 0);
    end

    // Random illegal words and random legal words with random stalls
    for (int i = 0; i < 60; i++) begin
      w = WW'($urandom);
      w[4*$urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
      run_word(w, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 60; i++) begin
      run_word(to_bcd(int'($urandom_range(0, 999))), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
